// File: rtl/led_pkg.sv
// Shared types and constants for the RGB PWM fader: duty width, PWM wrap value,
// fader FSM states and the packed colour struct.
package led_pkg;

    localparam int DUTY_W = 8;
    localparam logic [DUTY_W-1:0] PWM_MAX = 8'd255;

    typedef enum logic {
        IDLE   = 1'b0,
        FADING = 1'b1
    } state_t;

    typedef struct packed {
        logic [DUTY_W-1:0] r;
        logic [DUTY_W-1:0] g;
        logic [DUTY_W-1:0] b;
    } rgb_t;

endpackage

// File: rtl/pwm_channel.sv
// One colour channel: target/duty registers, single-LSB stepping toward the
// target on a shared strobe, and the registered PWM compare output.
module pwm_channel
    import led_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [DUTY_W-1:0] i_target,
    input  logic              i_step,
    input  logic [DUTY_W-1:0] i_pwm_cnt,
    output logic              o_at_target,
    output logic              o_led
);

    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DUTY_W-1:0] tgt_q, tgt_d;
    logic              led_q, led_d;

    assign o_at_target = (duty_q == tgt_q);
    assign o_led       = led_q;

    always_comb begin
        tgt_d  = tgt_q;
        duty_d = duty_q;
        if (i_load) begin
            tgt_d = i_target;
        end
        // The target bounds every step, so neither direction can wrap.
        if (i_step && (duty_q != tgt_q)) begin
            duty_d = (duty_q < tgt_q) ? duty_q + DUTY_W'(1) : duty_q - DUTY_W'(1);
        end
        led_d = (i_pwm_cnt < duty_q) ^ ACTIVE_LOW;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tgt_q  <= '0;
            duty_q <= '0;
            led_q  <= ACTIVE_LOW;
        end else begin
            tgt_q  <= tgt_d;
            duty_q <= duty_d;
            led_q  <= led_d;
        end
    end

endmodule

// File: rtl/rgb_pwm_fader.sv
// Three-channel 8-bit PWM driver that fades linearly to a colour accepted over
// valid/ready; duty changes only at PWM period boundaries.
module rgb_pwm_fader
    import led_pkg::*;
#(
    parameter int PRESC_DIV    = 48,
    parameter int FADE_PERIODS = 4,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [23:0] i_rgb,
    input  logic        i_valid,
    output logic        o_ready,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_led_r,
    output logic        o_led_g,
    output logic        o_led_b
);

    localparam int PRESC_W = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam int FADE_W  = (FADE_PERIODS > 1) ? $clog2(FADE_PERIODS) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC_DIV - 1);
    localparam logic [FADE_W-1:0]  FADE_LAST  = FADE_W'(FADE_PERIODS - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [DUTY_W-1:0]  pwm_cnt_q, pwm_cnt_d;
    logic [FADE_W-1:0]  fade_cnt_q, fade_cnt_d;
    state_t             state_q, state_d;
    logic               done_q, done_d;

    logic tick, period_end, load, step, all_at;
    logic at_r, at_g, at_b;
    rgb_t tgt_in;

    assign tgt_in     = rgb_t'(i_rgb);
    assign tick       = (presc_q == PRESC_LAST);
    assign period_end = tick && (pwm_cnt_q == PWM_MAX);
    assign all_at     = at_r && at_g && at_b;

    assign o_ready = (state_q == IDLE);
    assign o_busy  = (state_q == FADING);
    assign o_done  = done_q;

    always_comb begin
        presc_d   = tick ? '0 : presc_q + PRESC_W'(1);
        pwm_cnt_d = tick ? pwm_cnt_q + DUTY_W'(1) : pwm_cnt_q;
    end

    always_comb begin
        state_d    = state_q;
        fade_cnt_d = fade_cnt_q;
        done_d     = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_valid) begin
                    load       = 1'b1;
                    fade_cnt_d = '0;
                    state_d    = FADING;
                end
            end
            FADING: begin
                // Completion is tested before stepping, so IDLE follows one period after the last step.
                if (period_end) begin
                    if (all_at) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (fade_cnt_q == FADE_LAST) begin
                        fade_cnt_d = '0;
                        step       = 1'b1;
                    end else begin
                        fade_cnt_d = fade_cnt_q + FADE_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc_q    <= '0;
            pwm_cnt_q  <= '0;
            fade_cnt_q <= '0;
            state_q    <= IDLE;
            done_q     <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            pwm_cnt_q  <= pwm_cnt_d;
            fade_cnt_q <= fade_cnt_d;
            state_q    <= state_d;
            done_q     <= done_d;
        end
    end

    pwm_channel #(.ACTIVE_LOW(ACTIVE_LOW)) u_ch_r (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (load),
        .i_target   (tgt_in.r),
        .i_step     (step),
        .i_pwm_cnt  (pwm_cnt_q),
        .o_at_target(at_r),
        .o_led      (o_led_r)
    );

    pwm_channel #(.ACTIVE_LOW(ACTIVE_LOW)) u_ch_g (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (load),
        .i_target   (tgt_in.g),
        .i_step     (step),
        .i_pwm_cnt  (pwm_cnt_q),
        .o_at_target(at_g),
        .o_led      (o_led_g)
    );

    pwm_channel #(.ACTIVE_LOW(ACTIVE_LOW)) u_ch_b (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (load),
        .i_target   (tgt_in.b),
        .i_step     (step),
        .i_pwm_cnt  (pwm_cnt_q),
        .o_at_target(at_b),
        .o_led      (o_led_b)
    );

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Directed bench for rgb_pwm_fader: an active-high and an active-low instance
// share stimulus; a third instance (one period per step) fades to the duty extremes.
module tb_rgb_pwm_fader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [23:0] rgb, x_rgb;
    logic        valid, x_valid;
    logic        ready, busy, done, led_r, led_g, led_b;
    logic        ready_i, busy_i, done_i, led_ri, led_gi, led_bi;
    logic        x_ready, x_busy, x_done, led_rx, led_gx, led_bx;

    rgb_pwm_fader #(.PRESC_DIV(1), .FADE_PERIODS(2), .ACTIVE_LOW(1'b0)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rgb(rgb), .i_valid(valid),
        .o_ready(ready), .o_busy(busy), .o_done(done),
        .o_led_r(led_r), .o_led_g(led_g), .o_led_b(led_b)
    );

    rgb_pwm_fader #(.PRESC_DIV(1), .FADE_PERIODS(2), .ACTIVE_LOW(1'b1)) u_dut_al (
        .i_clk(clk), .i_rst_n(rst_n), .i_rgb(rgb), .i_valid(valid),
        .o_ready(ready_i), .o_busy(busy_i), .o_done(done_i),
        .o_led_r(led_ri), .o_led_g(led_gi), .o_led_b(led_bi)
    );

    rgb_pwm_fader #(.PRESC_DIV(1), .FADE_PERIODS(1), .ACTIVE_LOW(1'b0)) u_dut_x (
        .i_clk(clk), .i_rst_n(rst_n), .i_rgb(x_rgb), .i_valid(x_valid),
        .o_ready(x_ready), .o_busy(x_busy), .o_done(x_done),
        .o_led_r(led_rx), .o_led_g(led_gx), .o_led_b(led_bx)
    );

    // cyc = clock edges since reset release; pwm_cnt before edge n equals n % 256.
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int d_cnt = 0, d_cyc = 0, x_cnt = 0, x_cyc = 0;
    always @(negedge clk) begin
        if (done === 1'b1) begin
            d_cnt <= d_cnt + 1;
            d_cyc <= cyc;
        end
        if (x_done === 1'b1) begin
            x_cnt <= x_cnt + 1;
            x_cyc <= cyc;
        end
    end

    int n_chk = 0, n_err = 0;
    int cnt[9];
    int exp_r[6], exp_g[6], exp_b[6];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Edge index of the k-th period end after a transfer at edge nt (nt % 256 < 255).
    function automatic int pe(input int nt, input int k);
        return nt - (nt % 256) + 255 + 256 * (k - 1);
    endfunction

    task automatic wait_phase(input int ph);
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while ((cyc % 256) != ph && g < 300);
        if (g >= 300) chk("wait_phase_timeout", 0, 1);
    endtask

    // Counts LED highs over one whole PWM period of constant duty.
    task automatic measure();
        int g = 0;
        cnt = '{default: 0};
        do begin
            @(negedge clk);
            g++;
        end while ((cyc % 256) != 1 && g < 300);
        if (g >= 300) chk("measure_align_timeout", 0, 1);
        for (int i = 0; i < 256; i++) begin
            if (i > 0) @(negedge clk);
            cnt[0] += int'(led_r);  cnt[1] += int'(led_g);  cnt[2] += int'(led_b);
            cnt[3] += int'(led_ri); cnt[4] += int'(led_gi); cnt[5] += int'(led_bi);
            cnt[6] += int'(led_rx); cnt[7] += int'(led_gx); cnt[8] += int'(led_bx);
        end
    endtask

    task automatic check_win(input string tag, input int r, input int g, input int b);
        chk($sformatf("%s_r", tag), cnt[0], r);
        chk($sformatf("%s_g", tag), cnt[1], g);
        chk($sformatf("%s_b", tag), cnt[2], b);
        chk($sformatf("%s_r_al", tag), cnt[3], 256 - r);
        chk($sformatf("%s_g_al", tag), cnt[4], 256 - g);
        chk($sformatf("%s_b_al", tag), cnt[5], 256 - b);
    endtask

    task automatic check_fade(input string tag, input int nw);
        for (int k = 0; k < nw; k++) begin
            measure();
            check_win($sformatf("%s_p%0d", tag, k + 1), exp_r[k], exp_g[k], exp_b[k]);
        end
    endtask

    task automatic send(input logic [23:0] v, output int nt);
        wait_phase(100);
        nt    = cyc;
        rgb   = v;
        valid = 1'b1;
        @(negedge clk);
        chk("ready_drop", int'(ready), 0);
        chk("busy_rise", int'(busy), 1);
        valid = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nt, nx, d0, g;
        rst_n = 1'b0; valid = 1'b0; rgb = '0; x_valid = 1'b0; x_rgb = '0;
        repeat (3) @(negedge clk);
        chk("rst_led_r", int'(led_r), 0);
        chk("rst_led_r_al", int'(led_ri), 1);
        chk("rst_ready", int'(ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        rst_n = 1'b1;

        // Start a fade, then reset asynchronously while the red LED is lit.
        send(24'h030000, nt);
        measure();
        measure();
        check_win("pre_rst", 1, 0, 0);
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (led_r !== 1'b1 && g < 300);
        chk("led_on_before_rst", int'(led_r), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_led_r", int'(led_r), 0);
        chk("arst_led_r_al", int'(led_ri), 1);
        chk("arst_ready", int'(ready), 1);
        chk("arst_busy", int'(busy), 0);
        repeat (20) begin
            @(negedge clk);
            valid = 1'($urandom_range(0, 1));
            rgb   = 24'($urandom);
        end
        @(negedge clk);
        chk("rst_hold_led_g", int'(led_g), 0);
        chk("rst_hold_ready", int'(ready), 1);
        chk("rst_hold_busy", int'(busy), 0);
        valid = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            measure();
            check_win($sformatf("post_rst%0d", k), 0, 0, 0);
        end
        chk("post_rst_ready", int'(ready), 1);

        // Extreme instance: fade to 0xFF00FF in the background.
        wait_phase(50);
        nx      = cyc;
        x_rgb   = 24'hFF00FF;
        x_valid = 1'b1;
        @(negedge clk);
        chk("x_ready_drop", int'(x_ready), 0);
        x_valid = 1'b0;

        // Fade up 0 -> 0x030000.
        d0 = d_cnt;
        send(24'h030000, nt);
        exp_r = '{0, 1, 1, 2, 2, 3}; exp_g = '{0, 0, 0, 0, 0, 0}; exp_b = '{0, 0, 0, 0, 0, 0};
        check_fade("up", 6);
        @(negedge clk);
        chk("up_done_cnt", d_cnt - d0, 1);
        chk("up_done_cyc", d_cyc, pe(nt, 7) + 1);
        chk("up_ready", int'(ready), 1);
        chk("up_busy", int'(busy), 0);
        chk("up_done_low", int'(done), 0);
        measure();
        check_win("up_idle", 3, 0, 0);

        // Mixed directions: 0x030000 -> 0x000102.
        d0 = d_cnt;
        send(24'h000102, nt);
        exp_r = '{3, 2, 2, 1, 1, 0}; exp_g = '{0, 1, 1, 1, 1, 1}; exp_b = '{0, 1, 1, 2, 2, 2};
        check_fade("mix", 6);
        @(negedge clk);
        chk("mix_done_cnt", d_cnt - d0, 1);
        chk("mix_done_cyc", d_cyc, pe(nt, 7) + 1);
        chk("mix_ready", int'(ready), 1);

        // Same colour again: done after one period end.
        d0 = d_cnt;
        send(24'h000102, nt);
        measure();
        check_win("same", 0, 1, 2);
        chk("same_done_cnt", d_cnt - d0, 1);
        chk("same_done_cyc", d_cyc, pe(nt, 1) + 1);
        chk("same_ready", int'(ready), 1);

        // Back-pressure: 0xFFFFFF held during a fade to 0x020102.
        d0 = d_cnt;
        send(24'h020102, nt);
        rgb   = 24'hFFFFFF;
        valid = 1'b1;
        exp_r = '{0, 1, 1, 2, 0, 0}; exp_g = '{1, 1, 1, 1, 0, 0}; exp_b = '{2, 2, 2, 2, 0, 0};
        check_fade("bp", 4);
        chk("bp_ready_back", int'(ready), 1);
        @(negedge clk);
        chk("bp_ready_taken", int'(ready), 0);
        chk("bp_busy_taken", int'(busy), 1);
        chk("bp_done_cnt", d_cnt - d0, 1);
        chk("bp_done_cyc", d_cyc, pe(nt, 5) + 1);
        valid = 1'b0;

        // Extremes: duty 255 and duty 0.
        g = 0;
        while (x_cnt == 0 && g < 70000) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        chk("x_done_cnt", x_cnt, 1);
        chk("x_done_cyc", x_cyc, pe(nx, 256) + 1);
        chk("x_ready", int'(x_ready), 1);
        chk("x_busy", int'(x_busy), 0);
        measure();
        chk("x_r255", cnt[6], 255);
        chk("x_g0", cnt[7], 0);
        chk("x_b255", cnt[8], 255);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
